// File: rtl/flash_spi_arbiter.sv
// Shares the SPI configuration flash between an asynchronous external master
// (default owner, combinational passthrough) and an internal CLK-domain master.
module flash_spi_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int EXT_IDLE    = 16,
    parameter int GUARD       = 4
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic EXT_CS_n,
    input  logic EXT_CLK,
    input  logic EXT_DI,
    output logic EXT_DO,
    output logic EXT_BUSY,
    input  logic INT_REQ,
    output logic INT_GNT,
    input  logic INT_CS_n,
    input  logic INT_CLK,
    input  logic INT_DI,
    output logic INT_DO,
    output logic COLLISION,
    input  logic COLLISION_CLR,
    output logic FLASH_CS_n,
    output logic FLASH_CLK,
    output logic FLASH_DI,
    input  logic FLASH_DO
);

    localparam int IDLE_W  = $clog2(EXT_IDLE + 1);
    localparam int GUARD_W = $clog2(GUARD + 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(EXT_IDLE);
    // Guard counter counts down to zero, so loading GUARD-1 gives GUARD idle cycles.
    localparam logic [GUARD_W-1:0] GUARD_LD = GUARD_W'(GUARD - 1);

    typedef enum logic [1:0] {S_EXT, S_G2I, S_INT, S_G2E} state_t;

    state_t               state, state_nxt;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                 ext_cs_s;
    logic [IDLE_W-1:0]    idle_cnt, idle_nxt;
    logic [GUARD_W-1:0]   guard_cnt, guard_nxt;
    logic                 gnt_nxt, busy_nxt;

    assign ext_cs_s = cs_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) cs_sync <= '1;
        else          cs_sync <= {cs_sync[SYNC_STAGES-2:0], EXT_CS_n};
    end

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        guard_nxt = guard_cnt;
        gnt_nxt   = INT_GNT;
        busy_nxt  = EXT_BUSY;
        case (state)
            S_EXT: begin
                if (!ext_cs_s)
                    idle_nxt = '0;
                else if (idle_cnt != IDLE_MAX)
                    idle_nxt = idle_cnt + 1'b1;
                if (INT_REQ && idle_cnt == IDLE_MAX) begin
                    state_nxt = S_G2I;
                    guard_nxt = GUARD_LD;
                    busy_nxt  = 1'b1;
                end
            end
            S_G2I: begin
                // A request dropped here still completes the grant for one cycle.
                if (guard_cnt == '0) begin
                    state_nxt = S_INT;
                    gnt_nxt   = 1'b1;
                end else begin
                    guard_nxt = guard_cnt - 1'b1;
                end
            end
            S_INT: begin
                if (!INT_REQ) begin
                    state_nxt = S_G2E;
                    guard_nxt = GUARD_LD;
                    gnt_nxt   = 1'b0;
                end
            end
            S_G2E: begin
                if (guard_cnt == '0) begin
                    state_nxt = S_EXT;
                    busy_nxt  = 1'b0;
                    idle_nxt  = '0;
                end else begin
                    guard_nxt = guard_cnt - 1'b1;
                end
            end
            default: state_nxt = S_EXT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= S_EXT;
            idle_cnt  <= '0;
            guard_cnt <= '0;
            INT_GNT   <= 1'b0;
            EXT_BUSY  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idle_cnt  <= idle_nxt;
            guard_cnt <= guard_nxt;
            INT_GNT   <= gnt_nxt;
            EXT_BUSY  <= busy_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            COLLISION <= 1'b0;
        else if (!ext_cs_s && state != S_EXT)
            COLLISION <= 1'b1;
        else if (COLLISION_CLR)
            COLLISION <= 1'b0;
    end

    // External data stays purely combinational: EXT_CLK has no relation to CLK.
    always_comb begin
        FLASH_CS_n = 1'b1;
        FLASH_CLK  = 1'b0;
        FLASH_DI   = 1'b0;
        EXT_DO     = 1'b1;
        case (state)
            S_EXT: begin
                FLASH_CS_n = EXT_CS_n;
                FLASH_CLK  = EXT_CLK;
                FLASH_DI   = EXT_DI;
                EXT_DO     = FLASH_DO;
            end
            S_INT: begin
                FLASH_CS_n = INT_CS_n;
                FLASH_CLK  = INT_CLK;
                FLASH_DI   = INT_DI;
            end
            default: ;
        endcase
    end

    assign INT_DO = FLASH_DO;

endmodule

// File: tb/tb_flash_spi_arbiter.sv
// Directed bench for flash_spi_arbiter: passthrough, grant latency, collision,
// release with guard, and asynchronous reset while the internal master owns the flash.
module tb_flash_spi_arbiter;

    logic CLK = 1'b0;
    logic RESET_n;
    logic EXT_CS_n, EXT_CLK, EXT_DI, EXT_DO, EXT_BUSY;
    logic INT_REQ, INT_GNT, INT_CS_n, INT_CLK, INT_DI, INT_DO;
    logic COLLISION, COLLISION_CLR;
    logic FLASH_CS_n, FLASH_CLK, FLASH_DI, FLASH_DO;

    int n_chk  = 0;
    int n_fail = 0;

    flash_spi_arbiter #(.SYNC_STAGES(2), .EXT_IDLE(16), .GUARD(4)) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .EXT_CS_n(EXT_CS_n), .EXT_CLK(EXT_CLK), .EXT_DI(EXT_DI), .EXT_DO(EXT_DO),
        .EXT_BUSY(EXT_BUSY),
        .INT_REQ(INT_REQ), .INT_GNT(INT_GNT),
        .INT_CS_n(INT_CS_n), .INT_CLK(INT_CLK), .INT_DI(INT_DI), .INT_DO(INT_DO),
        .COLLISION(COLLISION), .COLLISION_CLR(COLLISION_CLR),
        .FLASH_CS_n(FLASH_CS_n), .FLASH_CLK(FLASH_CLK), .FLASH_DI(FLASH_DI),
        .FLASH_DO(FLASH_DO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] flash_pins();
        return {5'd0, FLASH_CS_n, FLASH_CLK, FLASH_DI};
    endfunction

    logic [3:0] vec [4];

    initial begin
        RESET_n = 1'b1;
        EXT_CS_n = 1'b1; EXT_CLK = 1'b0; EXT_DI = 1'b0;
        INT_REQ = 1'b0; INT_CS_n = 1'b1; INT_CLK = 1'b0; INT_DI = 1'b0;
        COLLISION_CLR = 1'b0; FLASH_DO = 1'b0;
        #2 RESET_n = 1'b0;
        #10;
        chk("rst_gnt",  {7'd0, INT_GNT},   8'd0);
        chk("rst_busy", {7'd0, EXT_BUSY},  8'd0);
        chk("rst_coll", {7'd0, COLLISION}, 8'd0);
        #10 RESET_n = 1'b1;

        // passthrough: {cs, clk, di, flash_do}
        vec[0] = 4'b0101; vec[1] = 4'b0010; vec[2] = 4'b1111; vec[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            {EXT_CS_n, EXT_CLK, EXT_DI, FLASH_DO} = vec[i];
            #1;
            chk("pass_pins", flash_pins(), {5'd0, vec[i][3:1]});
            chk("pass_do", {7'd0, EXT_DO}, {7'd0, vec[i][0]});
        end
        chk("pass_gnt", {7'd0, INT_GNT}, 8'd0);
        chk("pass_busy", {7'd0, EXT_BUSY}, 8'd0);

        // grant after long external idle
        EXT_CS_n = 1'b1; EXT_CLK = 1'b0; EXT_DI = 1'b0;
        repeat (20) tick();
        INT_REQ = 1'b1;
        tick();
        chk("g2i_busy", {7'd0, EXT_BUSY}, 8'd1);
        chk("g2i_cs", {7'd0, FLASH_CS_n}, 8'd1);
        chk("g2i_gnt", {7'd0, INT_GNT}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("g2i_guard_cs", {7'd0, FLASH_CS_n}, 8'd1);
            chk("g2i_guard_gnt", {7'd0, INT_GNT}, 8'd0);
        end
        tick();
        chk("gnt_cycle5", {7'd0, INT_GNT}, 8'd1);
        INT_CS_n = 1'b0; INT_CLK = 1'b1; INT_DI = 1'b1; FLASH_DO = 1'b1;
        #1;
        chk("int_pins_a", flash_pins(), 8'b011);
        chk("int_do_a", {7'd0, INT_DO}, 8'd1);
        chk("int_extdo_a", {7'd0, EXT_DO}, 8'd1);
        INT_CS_n = 1'b1; INT_CLK = 1'b0; INT_DI = 1'b1; FLASH_DO = 1'b0;
        #1;
        chk("int_pins_b", flash_pins(), 8'b101);
        chk("int_do_b", {7'd0, INT_DO}, 8'd0);
        chk("int_extdo_b", {7'd0, EXT_DO}, 8'd1);

        // collision while internal owns the flash
        tick();
        EXT_CS_n = 1'b0;
        tick(); tick();
        chk("coll_early", {7'd0, COLLISION}, 8'd0);
        tick();
        chk("coll_set", {7'd0, COLLISION}, 8'd1);
        chk("coll_cs_int", {7'd0, FLASH_CS_n}, 8'd1);
        chk("coll_extdo", {7'd0, EXT_DO}, 8'd1);
        INT_CS_n = 1'b0;
        #1;
        chk("coll_cs_int0", {7'd0, FLASH_CS_n}, 8'd0);
        EXT_CS_n = 1'b1;
        repeat (4) tick();
        chk("coll_sticky", {7'd0, COLLISION}, 8'd1);
        COLLISION_CLR = 1'b1;
        tick();
        COLLISION_CLR = 1'b0;
        chk("coll_clr", {7'd0, COLLISION}, 8'd0);

        // release while INT_CS_n is low
        EXT_CLK = 1'b1; EXT_DI = 1'b1; FLASH_DO = 1'b0;
        INT_REQ = 1'b0;
        tick();
        chk("rel_gnt", {7'd0, INT_GNT}, 8'd0);
        chk("rel_pins", flash_pins(), 8'b100);
        chk("rel_busy", {7'd0, EXT_BUSY}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rel_guard_pins", flash_pins(), 8'b100);
            chk("rel_guard_extdo", {7'd0, EXT_DO}, 8'd1);
        end
        tick();
        chk("rel_busy_off", {7'd0, EXT_BUSY}, 8'd0);
        chk("rel_pass_pins", flash_pins(), 8'b111);
        chk("rel_pass_do", {7'd0, EXT_DO}, 8'd0);

        // request during external transaction waits for 16 idle cycles
        INT_CS_n = 1'b1; EXT_CLK = 1'b0; EXT_DI = 1'b0;
        EXT_CS_n = 1'b0;
        repeat (4) tick();
        INT_REQ = 1'b1;
        repeat (10) tick();
        chk("wait_busy", {7'd0, EXT_BUSY}, 8'd0);
        chk("wait_cs", {7'd0, FLASH_CS_n}, 8'd0);
        chk("wait_coll", {7'd0, COLLISION}, 8'd0);
        EXT_CS_n = 1'b1;
        repeat (18) tick();
        chk("idle_not_yet", {7'd0, EXT_BUSY}, 8'd0);
        tick();
        chk("idle_busy", {7'd0, EXT_BUSY}, 8'd1);
        repeat (3) tick();
        chk("idle_gnt_pre", {7'd0, INT_GNT}, 8'd0);
        tick();
        chk("idle_gnt", {7'd0, INT_GNT}, 8'd1);

        // async reset while internal owns the flash
        INT_CS_n = 1'b0; INT_CLK = 1'b1; INT_DI = 1'b0;
        EXT_CS_n = 1'b1; EXT_CLK = 1'b0; EXT_DI = 1'b1;
        #1;
        chk("pre_rst_pins", flash_pins(), 8'b010);
        #1 RESET_n = 1'b0;
        #1;
        chk("arst_gnt", {7'd0, INT_GNT}, 8'd0);
        chk("arst_busy", {7'd0, EXT_BUSY}, 8'd0);
        chk("arst_pins", flash_pins(), 8'b101);
        INT_REQ = 1'b0;
        #2 RESET_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_gnt", {7'd0, INT_GNT}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
